// File: rtl/mmul_parallel_job_launcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmul_parallel_launcher_package
// Brief    : Shared types and register-map constants for the mmul_parallel
//            job launcher.
// Revision : 1.0 - initial release
// ============================================================================
package mmul_parallel_launcher_package;

   // State literals carry an ST_ prefix so they cannot collide with the
   // launcher's BACKOFF parameter once the package is wildcard-imported.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACQ      = 3'd1,
      ST_ACQ_WAIT = 3'd2,
      ST_BACKOFF  = 3'd3,
      ST_WRITE    = 3'd4,
      ST_TRIGGER  = 3'd5,
      ST_WAIT_EVT = 3'd6
   } launcher_state_t;

   localparam logic [31:0] OFS_TRIGGER = 32'h0000_0000;
   localparam logic [31:0] OFS_ACQUIRE = 32'h0000_0004;
   localparam logic [31:0] OFS_JOB     = 32'h0000_0040;
   localparam logic [31:0] LOCKED      = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/mmul_parallel_job_launcher_if.sv
`default_nettype none
// ============================================================================
// Module   : mmul_parallel_job_launcher_if
// Brief    : HWPE peripheral (periph) bus between an initiator and a target.
// Revision : 1.0 - initial release
// ============================================================================
interface mmul_parallel_job_launcher_if #(
   parameter int unsigned ID_WIDTH = 10
) ();
   logic                req;
   logic                gnt;
   logic [31:0]         add;
   logic                wen;
   logic [3:0]          be;
   logic [31:0]         data;
   logic [ID_WIDTH-1:0] id;
   logic [31:0]         r_data;
   logic                r_valid;
   logic [ID_WIDTH-1:0] r_id;

   modport master (
      output req, add, wen, be, data, id,
      input  gnt, r_data, r_valid, r_id
   );

   modport slave (
      input  req, add, wen, be, data, id,
      output gnt, r_data, r_valid, r_id
   );
endinterface
`default_nettype wire

// File: rtl/mmul_parallel_job_launcher.sv
`default_nettype none
// ============================================================================
// Module   : mmul_parallel_job_launcher
// Brief    : Periph-bus initiator that acquires an mmul_parallel accelerator,
//            programs its job registers, triggers it and waits for end-of-job.
// Revision : 1.0 - initial release
// ============================================================================
module mmul_parallel_job_launcher
   import mmul_parallel_launcher_package::*;
#(
   parameter int unsigned N_IO_REGS    = 16,
   parameter int unsigned N_PARAM_REGS = 4,
   parameter int unsigned ID_WIDTH     = 10,
   parameter logic [31:0] BASE_ADDR    = 32'h0,
   parameter int unsigned BACKOFF      = 8
) (
   input  wire logic                                        clk_i,
   input  wire logic                                        rst_ni,
   input  wire logic                                        clear_i,
   input  wire logic                                        job_valid_i,
   output logic                                             job_ready_o,
   input  wire logic [N_IO_REGS+N_PARAM_REGS-1:0][31:0]     job_regs_i,
   mmul_parallel_job_launcher_if.master                     periph,
   input  wire logic                                        evt_i,
   output logic                                             busy_o,
   output logic [7:0]                                       job_id_o,
   output logic                                             done_o
);

   localparam int unsigned c_N_REGS = N_IO_REGS + N_PARAM_REGS;
   localparam int unsigned c_IDX_W  = $clog2(c_N_REGS + 1);
   localparam int unsigned c_BK_W   = $clog2(BACKOFF + 1);
   localparam int unsigned c_CNT_W  = (c_IDX_W > c_BK_W) ? c_IDX_W : c_BK_W;
   localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_N_REGS - 1);
   localparam logic [c_CNT_W-1:0] c_LAST_BK  = c_CNT_W'(BACKOFF - 1);

   launcher_state_t                 r_state;
   logic [c_N_REGS-1:0][31:0]       r_regs;
   // Write index in WRITE, backoff counter in BACKOFF; never live together.
   logic [c_CNT_W-1:0]              r_cnt;
   logic                            r_req;
   logic                            r_wen;
   logic [31:0]                     r_add;
   logic [31:0]                     r_data;
   logic [7:0]                      r_job_id;
   logic [c_CNT_W-1:0]              w_idx_nxt;

   assign w_idx_nxt   = r_cnt + c_CNT_W'(1);

   assign periph.req  = r_req;
   assign periph.wen  = r_wen;
   assign periph.add  = r_add;
   assign periph.data = r_data;
   assign periph.be   = 4'hF;
   assign periph.id   = '0;

   assign job_ready_o = (r_state == ST_IDLE);
   assign busy_o      = (r_state != ST_IDLE);
   assign job_id_o    = r_job_id;
   // Pulse coincides with the WAIT_EVT -> IDLE transition cycle.
   assign done_o      = (r_state == ST_WAIT_EVT) && evt_i && !clear_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_IDLE;
         r_regs   <= '0;
         r_cnt    <= '0;
         r_req    <= 1'b0;
         r_wen    <= 1'b0;
         r_add    <= '0;
         r_data   <= '0;
         r_job_id <= '0;
      end else if (clear_i) begin
         r_state  <= ST_IDLE;
         r_regs   <= '0;
         r_cnt    <= '0;
         r_req    <= 1'b0;
         r_wen    <= 1'b0;
         r_add    <= '0;
         r_data   <= '0;
         r_job_id <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (job_valid_i) begin
                  r_regs  <= job_regs_i;
                  r_req   <= 1'b1;
                  r_wen   <= 1'b1;
                  r_add   <= BASE_ADDR + OFS_ACQUIRE;
                  r_state <= ST_ACQ;
               end
            end
            ST_ACQ: begin
               if (periph.gnt) begin
                  r_req   <= 1'b0;
                  r_state <= ST_ACQ_WAIT;
               end
            end
            ST_ACQ_WAIT: begin
               if (periph.r_valid && (periph.r_id == '0)) begin
                  r_cnt <= '0;
                  if (periph.r_data == LOCKED) begin
                     r_state <= ST_BACKOFF;
                  end else begin
                     r_job_id <= periph.r_data[7:0];
                     r_req    <= 1'b1;
                     r_wen    <= 1'b0;
                     r_add    <= BASE_ADDR + OFS_JOB;
                     r_data   <= r_regs[0];
                     r_state  <= ST_WRITE;
                  end
               end
            end
            ST_BACKOFF: begin
               if (r_cnt == c_LAST_BK) begin
                  r_req   <= 1'b1;
                  r_wen   <= 1'b1;
                  r_add   <= BASE_ADDR + OFS_ACQUIRE;
                  r_state <= ST_ACQ;
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            ST_WRITE: begin
               // Request stays high across the burst; only address/data advance.
               if (periph.gnt) begin
                  if (r_cnt == c_LAST_IDX) begin
                     r_add   <= BASE_ADDR + OFS_TRIGGER;
                     r_data  <= '0;
                     r_state <= ST_TRIGGER;
                  end else begin
                     r_cnt  <= w_idx_nxt;
                     r_add  <= r_add + 32'd4;
                     r_data <= r_regs[w_idx_nxt];
                  end
               end
            end
            ST_TRIGGER: begin
               if (periph.gnt) begin
                  r_req   <= 1'b0;
                  r_state <= ST_WAIT_EVT;
               end
            end
            ST_WAIT_EVT: begin
               if (evt_i) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
